// File: rtl/pmc_req_sequencer.sv
// pmc_req_sequencer: shares one bus between PMC link commands and CPU requests, and builds the 96-bit response frame
module pmc_req_sequencer #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  END_BYTE = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_req,
  input  logic [23:0] ext_addr,
  input  logic [31:0] ext_data,
  input  logic        ext_write,
  input  logic        ext_read,
  input  logic        ext_error,
  output logic        ext_ovf,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [23:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [95:0] tx_msg,
  output logic        tx_start,
  input  logic        tx_busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_pend_q, ext_pend_d;
  logic [23:0] ext_addr_q, ext_addr_d;
  logic [31:0] ext_data_q, ext_data_d;
  logic        ext_write_q, ext_write_d;
  logic        ext_read_q, ext_read_d;
  logic        ext_error_q, ext_error_d;
  logic        ext_ovf_q, ext_ovf_d;
  logic        last_gnt_q, last_gnt_d;
  logic        gnt_q, gnt_d;
  logic [15:0] timer_q, timer_d;
  logic [95:0] tx_msg_q, tx_msg_d;
  logic        tx_start_q, tx_start_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_err_q, cpu_err_d;
  logic        in_bus, hit, tmo, ext_rise, ext_busy, ext_bad, pick_ext;
  logic [15:0] hdr;
  logic [31:0] fdata;
  logic [7:0]  code;
  logic [95:0] msg;
  assign in_bus   = state_q == BUS;
  assign hit      = in_bus & bus_ack;
  assign tmo      = in_bus & ~bus_ack & (timer_q == 16'(TIMEOUT - 1));
  assign ext_rise = ext_req & ~ext_req_q;
  assign ext_busy = ext_pend_q | ((state_q != IDLE) & gnt_q);
  assign ext_bad  = ext_error_q | ~(ext_read_q ^ ext_write_q);
  assign pick_ext = ext_pend_q & (~cpu_req | ~last_gnt_q);
  assign hdr      = (ext_read_q ^ ext_write_q) ? {14'd0, ext_write_q, ext_read_q} : 16'd0;
  assign fdata    = (ext_read_q & ~ext_write_q) ? (hit ? bus_rdata : 32'd0) : ext_data_q;
  assign code     = ext_error_q ? 8'h01 : ext_bad ? 8'h03 : hit ? 8'h00 : 8'h02;
  assign msg      = {8'h0F, hdr, fdata, ext_addr_q, code, END_BYTE};
  assign bus_addr  = in_bus ? (gnt_q ? ext_addr_q : cpu_addr) : 24'd0;
  assign bus_wdata = in_bus ? (gnt_q ? ext_data_q : cpu_wdata) : 32'd0;
  assign bus_we    = in_bus & (gnt_q ? ext_write_q : cpu_we);
  assign bus_re    = in_bus & (gnt_q ? ext_read_q : ~cpu_we);
  assign cpu_done  = state_q == DONE;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign tx_msg    = tx_msg_q;
  assign tx_start  = tx_start_q;
  assign ext_ovf   = ext_ovf_q;
  // next-state: ext edge capture, round-robin grant, bus timing and frame build
  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req;
    ext_pend_d  = ext_pend_q;
    ext_addr_d  = ext_addr_q;
    ext_data_d  = ext_data_q;
    ext_write_d = ext_write_q;
    ext_read_d  = ext_read_q;
    ext_error_d = ext_error_q;
    ext_ovf_d   = ext_ovf_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    timer_d     = timer_q;
    tx_msg_d    = tx_msg_q;
    tx_start_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    if (ext_rise) begin
      if (ext_busy) ext_ovf_d = 1'b1;
      else begin
        ext_pend_d  = 1'b1;
        ext_addr_d  = ext_addr;
        ext_data_d  = ext_data;
        ext_write_d = ext_write;
        ext_read_d  = ext_read;
        ext_error_d = ext_error;
      end
    end
    case (state_q)
      IDLE: if (ext_pend_q | cpu_req) begin
        gnt_d      = pick_ext;
        last_gnt_d = pick_ext;
        timer_d    = 16'd0;
        state_d    = BUS;
        if (pick_ext) begin
          ext_pend_d = 1'b0;
          if (ext_bad) begin
            state_d  = RESP;
            tx_msg_d = msg;
          end
        end
      end
      BUS: if (hit | tmo) begin
        state_d = gnt_q ? RESP : DONE;
        timer_d = 16'd0;
        if (gnt_q) tx_msg_d = msg;
        else begin
          cpu_err_d   = tmo;
          cpu_rdata_d = (hit & ~cpu_we) ? bus_rdata : cpu_rdata_q;
        end
      end else timer_d = timer_q + 16'd1;
      RESP: if (!tx_busy) begin
        tx_start_d = 1'b1;
        state_d    = IDLE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ext_req_q   <= 1'b0;
      ext_pend_q  <= 1'b0;
      ext_addr_q  <= 24'd0;
      ext_data_q  <= 32'd0;
      ext_write_q <= 1'b0;
      ext_read_q  <= 1'b0;
      ext_error_q <= 1'b0;
      ext_ovf_q   <= 1'b0;
      last_gnt_q  <= 1'b0;
      gnt_q       <= 1'b0;
      timer_q     <= 16'd0;
      tx_msg_q    <= 96'd0;
      tx_start_q  <= 1'b0;
      cpu_rdata_q <= 32'd0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_pend_q  <= ext_pend_d;
      ext_addr_q  <= ext_addr_d;
      ext_data_q  <= ext_data_d;
      ext_write_q <= ext_write_d;
      ext_read_q  <= ext_read_d;
      ext_error_q <= ext_error_d;
      ext_ovf_q   <= ext_ovf_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      timer_q     <= timer_d;
      tx_msg_q    <= tx_msg_d;
      tx_start_q  <= tx_start_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
    end
  end
endmodule

// File: tb/tb_pmc_req_sequencer.sv
// tb_pmc_req_sequencer: table-driven ext frames, hand-written CPU/corner sequences, scoreboarded frames and done pulses
module tb_pmc_req_sequencer;
  logic clk = 1'b0, reset = 1'b0;
  logic ext_req = 1'b0, ext_write = 1'b0, ext_read = 1'b0, ext_error = 1'b0, ext_ovf;
  logic [23:0] ext_addr = '0, cpu_addr = '0, bus_addr;
  logic [31:0] ext_data = '0, cpu_wdata = '0, cpu_rdata, bus_wdata, bus_rdata = '0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_done, cpu_err;
  logic bus_we, bus_re, bus_ack = 1'b0;
  logic [95:0] tx_msg;
  logic tx_start, tx_busy = 1'b0;
  pmc_req_sequencer #(.TIMEOUT(8), .END_BYTE(8'hF0)) dut (
    .clk(clk), .reset(reset),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_data(ext_data), .ext_write(ext_write),
    .ext_read(ext_read), .ext_error(ext_error), .ext_ovf(ext_ovf),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .tx_msg(tx_msg), .tx_start(tx_start), .tx_busy(tx_busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic w, r, e;
    logic [23:0] addr;
    logic [31:0] data;
    int dly;
    logic [31:0] rdat;
    int ewe, ere, lat;
    logic [95:0] msg;
  } vec_t;
  typedef struct {
    logic [31:0] rd;
    logic err;
    logic chk_rd;
  } cexp_t;
  vec_t vecs[7];
  logic [95:0] msg_q[$];
  cexp_t cpu_q[$];
  cexp_t ce;
  int checks = 0, passes = 0;
  int cyc = 0, t_rise = 0, t_tx = 0, t_rel = 0;
  int we_cnt = 0, re_cnt = 0, tx_cnt = 0, dn_cnt = 0;
  int ack_dly = 1, rcnt = 0;
  logic [31:0] rd_val = '0;
  string order = "";
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // bus slave: acks on the ack_dly-th strobe cycle, never when ack_dly is 0
  always @(negedge clk) begin
    if (bus_we || bus_re) begin
      rcnt = rcnt + 1;
      bus_ack = (ack_dly != 0) && (rcnt == ack_dly);
      bus_rdata = bus_ack ? rd_val : 32'h0;
    end else begin
      rcnt = 0;
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
    end
  end
  // output monitor: strobe accounting and scoreboard pops
  always @(negedge clk) begin
    if (bus_we) we_cnt++;
    if (bus_re) re_cnt++;
    if (bus_we && bus_re) begin
      checks++;
      $display("FAIL strobe_excl: got we=1 re=1, required at most one strobe");
    end
    if (tx_start) begin
      tx_cnt++;
      t_tx = cyc;
      order = {order, "E"};
      if (msg_q.size() == 0) begin
        checks++;
        $display("FAIL tx_unexpected: got frame %h, required no frame", tx_msg);
      end else chk("tx_msg", tx_msg, msg_q.pop_front());
    end
    if (cpu_done) begin
      dn_cnt++;
      order = {order, "C"};
      if (cpu_q.size() == 0) begin
        checks++;
        $display("FAIL done_unexpected: got cpu_done=1, required no done");
      end else begin
        ce = cpu_q.pop_front();
        chk("cpu_err", 96'(cpu_err), 96'(ce.err));
        if (ce.chk_rd) chk("cpu_rdata", 96'(cpu_rdata), 96'(ce.rd));
      end
    end
  end
  task automatic ext_send(input logic w, input logic r, input logic e, input logic [23:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    ext_write = w; ext_read = r; ext_error = e; ext_addr = a; ext_data = d;
    ext_req = 1'b1;
    t_rise = cyc;
    repeat (2) @(posedge clk);
    #1 ext_req = 1'b0;
  endtask
  task automatic cpu_txn(input logic we, input logic [23:0] a, input logic [31:0] d);
    int k;
    @(posedge clk);
    #1;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_done && k < 100);
    if (!cpu_done) begin
      checks++;
      $display("FAIL cpu_wait: got no cpu_done in %0d cycles, required one", k);
    end
    cpu_req = 1'b0;
  endtask
  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((msg_q.size() != 0 || cpu_q.size() != 0) && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      $display("FAIL %s: got %0d frames and %0d dones outstanding, required 0", nm, msg_q.size(), cpu_q.size());
      msg_q.delete();
      cpu_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    int s_we, s_re, s_tx, s_dn, base;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 24'h000010, 32'hDEADBEEF, 3, 32'h0, 3, 0, 0, 96'h0F_0002_DEADBEEF_000010_00_F0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 24'h000020, 32'hAAAAAAAA, 1, 32'h12345678, 0, 1, 4, 96'h0F_0001_12345678_000020_00_F0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 24'h000030, 32'h0BADF00D, 0, 32'h0, 8, 0, 0, 96'h0F_0002_0BADF00D_000030_02_F0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 24'h000050, 32'hCAFEBABE, 1, 32'h0, 0, 0, 0, 96'h0F_0002_CAFEBABE_000050_01_F0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 24'h000060, 32'h11223344, 1, 32'h0, 0, 0, 0, 96'h0F_0000_11223344_000060_03_F0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 1, 0, 4, 96'h0F_0002_FFFFFFFF_FFFFFF_00_F0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 24'h000070, 32'h0, 8, 32'h55AA55AA, 0, 8, 0, 96'h0F_0001_55AA55AA_000070_00_F0};
    #12;
    chk("rst_tx_msg", tx_msg, 96'h0);
    chk("rst_tx_start", 96'(tx_start), 96'h0);
    chk("rst_cpu_done", 96'(cpu_done), 96'h0);
    chk("rst_strobes", 96'({bus_we, bus_re}), 96'h0);
    chk("rst_bus_addr", 96'(bus_addr), 96'h0);
    chk("rst_ext_ovf", 96'(ext_ovf), 96'h0);
    chk("rst_cpu_rdata", 96'(cpu_rdata), 96'h0);
    chk("rst_cpu_err", 96'(cpu_err), 96'h0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      ack_dly = vecs[i].dly;
      rd_val = vecs[i].rdat;
      s_we = we_cnt; s_re = re_cnt; s_tx = tx_cnt;
      msg_q.push_back(vecs[i].msg);
      ext_send(vecs[i].w, vecs[i].r, vecs[i].e, vecs[i].addr, vecs[i].data);
      drain("vec_drain");
      chk("vec_we_cycles", 96'(we_cnt - s_we), 96'(vecs[i].ewe));
      chk("vec_re_cycles", 96'(re_cnt - s_re), 96'(vecs[i].ere));
      chk("vec_tx_count", 96'(tx_cnt - s_tx), 96'd1);
      if (vecs[i].lat != 0) chk("vec_latency", 96'(t_tx - t_rise), 96'(vecs[i].lat));
    end
    s_dn = dn_cnt;
    ack_dly = 1;
    s_we = we_cnt;
    cpu_q.push_back('{32'h0, 1'b0, 1'b0});
    cpu_txn(1'b1, 24'h800000, 32'h13572468);
    drain("cpu_wr_drain");
    chk("cpu_wr_we", 96'(we_cnt - s_we), 96'd1);
    ack_dly = 2;
    rd_val = 32'h87654321;
    s_re = re_cnt;
    cpu_q.push_back('{32'h87654321, 1'b0, 1'b1});
    cpu_txn(1'b0, 24'h800004, 32'h0);
    drain("cpu_rd_drain");
    chk("cpu_rd_re", 96'(re_cnt - s_re), 96'd2);
    ack_dly = 1;
    rd_val = 32'hFFFF0000;
    cpu_q.push_back('{32'h87654321, 1'b0, 1'b1});
    cpu_txn(1'b1, 24'h800008, 32'h2468ACE0);
    drain("cpu_hold_drain");
    ack_dly = 0;
    s_re = re_cnt;
    cpu_q.push_back('{32'h0, 1'b1, 1'b0});
    cpu_txn(1'b0, 24'h80000C, 32'h0);
    drain("cpu_tmo_drain");
    chk("cpu_tmo_re", 96'(re_cnt - s_re), 96'd8);
    chk("cpu_done_count", 96'(dn_cnt - s_dn), 96'd4);
    ack_dly = 1;
    tx_busy = 1'b1;
    s_tx = tx_cnt;
    msg_q.push_back(96'h0F_0002_01020304_000090_00_F0);
    ext_send(1'b1, 1'b0, 1'b0, 24'h000090, 32'h01020304);
    repeat (12) @(posedge clk);
    #1;
    chk("busy_no_start", 96'(tx_cnt - s_tx), 96'd0);
    tx_busy = 1'b0;
    t_rel = cyc;
    drain("busy_drain");
    chk("busy_start_delay", 96'(t_tx - t_rel), 96'd1);
    chk("busy_tx_count", 96'(tx_cnt - s_tx), 96'd1);
    chk("tx_msg_held", tx_msg, 96'h0F_0002_01020304_000090_00_F0);
    chk("ovf_before", 96'(ext_ovf), 96'h0);
    ack_dly = 6;
    s_tx = tx_cnt;
    msg_q.push_back(96'h0F_0002_0000AAAA_0000A0_00_F0);
    ext_send(1'b1, 1'b0, 1'b0, 24'h0000A0, 32'h0000AAAA);
    ext_send(1'b0, 1'b1, 1'b0, 24'h0000A4, 32'h0);
    drain("ovf_drain");
    chk("ovf_set", 96'(ext_ovf), 96'h1);
    chk("ovf_tx_count", 96'(tx_cnt - s_tx), 96'd1);
    ack_dly = 0;
    s_tx = tx_cnt;
    ext_send(1'b1, 1'b0, 1'b0, 24'h0000B0, 32'h0000BBBB);
    chk("rst_mid_we", 96'(bus_we), 96'h1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_strobes", 96'({bus_we, bus_re}), 96'h0);
    chk("rst_mid_tx_msg", tx_msg, 96'h0);
    chk("rst_mid_ovf", 96'(ext_ovf), 96'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    s_we = we_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_frame", 96'(tx_cnt - s_tx), 96'd0);
    chk("rst_no_strobe", 96'(we_cnt - s_we), 96'd0);
    ack_dly = 1;
    rd_val = 32'h0A0B0C0D;
    cpu_we = 1'b0;
    cpu_addr = 24'h800100;
    order = "";
    s_tx = tx_cnt; s_dn = dn_cnt; base = tx_cnt;
    for (int i = 0; i < 3; i++) begin
      msg_q.push_back({8'h0F, 16'h0002, 32'h50000000 + 32'(i), 24'h0000C0 + 24'(i), 8'h00, 8'hF0});
      cpu_q.push_back('{32'h0A0B0C0D, 1'b0, 1'b1});
    end
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int k;
          ext_send(1'b1, 1'b0, 1'b0, 24'h0000C0 + 24'(i), 32'h50000000 + 32'(i));
          k = 0;
          while (tx_cnt < base + i + 1 && k < 200) begin
            @(negedge clk);
            k++;
          end
        end
      end
      begin
        int n, k;
        n = 0; k = 0;
        repeat (2) @(posedge clk);
        #1 cpu_req = 1'b1;
        while (n < 3 && k < 400) begin
          @(negedge clk);
          k++;
          if (cpu_done) n++;
        end
        cpu_req = 1'b0;
      end
    join
    drain("arb_drain");
    chk("arb_order", 96'(order == "ECECEC"), 96'h1);
    chk("arb_tx_count", 96'(tx_cnt - s_tx), 96'd3);
    chk("arb_done_count", 96'(dn_cnt - s_dn), 96'd3);
    if (order != "ECECEC") $display("arbitration order seen: %s", order);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pmc_req_sequencer.md
# pmc_req_sequencer

Sequences decoded PMC link commands and local CPU requests onto the single shared peripheral/memory bus, and builds the 96-bit response frame for the link transmitter. It sits between the PMC frame decoder (ext_* inputs) and the UART TX framer (tx_*), and arbitrates the bus round-robin against the CPU port. All external transactions produce exactly one response frame; CPU transactions complete with a one-cycle done pulse.

## Interface
- TIMEOUT, 255: max cycles waiting for bus_ack before abort (1..65535)
- END_BYTE, 8'hF0: trailer byte placed in tx_msg[7:0]
- clk  in  1  system clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- ext_req  in  1  decoder request level (held high while frame valid)
- ext_addr  in  24  decoded address
- ext_data  in  32  decoded write data
- ext_write  in  1  header was 0x0002
- ext_read  in  1  header was 0x0001
- ext_error  in  1  frame error byte nonzero
- ext_ovf  out  1  sticky: new ext request arrived while one pending
- cpu_req  in  1  CPU request level, held until cpu_done
- cpu_addr  in  24  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_we  in  1  1 = write, 0 = read
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid with cpu_done, held until next done
- cpu_err  out  1  timeout flag, valid with cpu_done
- bus_addr  out  24  bus address
- bus_wdata  out  32  bus write data
- bus_we  out  1  bus write strobe
- bus_re  out  1  bus read strobe
- bus_ack  in  1  bus completion, one cycle
- bus_rdata  in  32  bus read data, valid with bus_ack
- tx_msg  out  96  response frame
- tx_start  out  1  one-cycle launch pulse to framer
- tx_busy  in  1  framer busy

## Operation
- ext_req registered to ext_req_q; rising edge (ext_req & ~ext_req_q) sets ext_pend and latches addr/data/write/read/error. Edge while ext_pend=1 or FSM serving ext: request dropped, ext_ovf set.
- cpu_req is level; pending whenever high and not being served.
- FSM states: IDLE, BUS, RESP, DONE.
- IDLE: if both pending, grant the one not granted last (last_gnt reg, reset = CPU so ext wins first tie); else grant the single pending one. Ext with error=1 or read=write=0 skips BUS, goes RESP with error code.
- BUS: bus_addr/wdata/we/re driven from granted source; exactly one strobe high; timer counts cycles in BUS. bus_ack -> capture bus_rdata, err=0; timer == TIMEOUT-1 without ack -> err=timeout. Exit to RESP (ext) or DONE (CPU); strobes drop on exit.
- RESP: tx_msg built: [95:88]=0x0F, [87:72]=0x0001 read / 0x0002 write / 0x0000 invalid, [71:40]=read data (read) or echoed write data, [39:16]=addr, [15:8]=error code (0x00 ok, 0x01 frame error, 0x02 timeout, 0x03 invalid header), [7:0]=END_BYTE. Waits while tx_busy=1; when tx_busy=0 pulses tx_start and returns IDLE; tx_msg held until the next RESP.
- DONE: cpu_done=1 one cycle with cpu_rdata (reads only updated on read) and cpu_err; return IDLE.
- Priority of simultaneous events: bus_ack wins over timeout on the same cycle.
- Reset mid-operation: transaction abandoned, no frame, no done pulse.

## Timing
- Reset values: all outputs 0, tx_msg 0, ext_ovf 0, FSM IDLE, timer 0, ext_pend 0, last_gnt CPU.
- Ext edge at cycle 0 edge -> ext_pend at edge 1 -> grant, BUS entered edge 2; strobes visible from cycle after edge 2.
- Zero-wait ack (ack in first BUS cycle) -> RESP next edge -> tx_start one cycle later if tx_busy=0. Ext latency ext_req rise to tx_start: 4 cycles minimum.
- CPU: cpu_req high at IDLE edge -> BUS next cycle; ack -> DONE -> cpu_done pulse; min 3 cycles.
- Timeout: strobes high exactly TIMEOUT cycles.
- Controller returns to IDLE for exactly one cycle between transactions.

## Test plan
- Ext write addr 0x000010 data 0xDEADBEEF, ack after 3 cycles -> bus_we 3 cycles, tx_msg = 0x0F_0002_DEADBEEF_000010_00_F0, one tx_start.
- Ext read addr 0x000020, bus_rdata 0x12345678 -> tx_msg header 0x0001, data 0x12345678, error 0x00.
- cpu_req and ext edge same cycle, both repeating -> ext served first, then CPU, then alternation; no starvation.
- No ack, TIMEOUT=8 -> strobes 8 cycles, ext frame error 0x02; CPU variant cpu_err=1 with cpu_done.
- ext_error=1 -> no bus strobe, frame error 0x01; read=write=0 -> header 0x0000, error 0x03; second ext edge during service -> ext_ovf=1.
- tx_busy held high 10 cycles in RESP -> tx_start delayed until tx_busy low; reset asserted in BUS -> strobes drop immediately, no frame after release.
